hilo_div_unit: RTL
==================

// Module: hilo_div_unit
// PURPOSE
// Iterative multi-cycle divider that produces the HI/LO values consumed by the
// decode stage's hi/lo registers (HasDivW/DivHiW/DivLoW path).
// - Sits in the execute stage.
// - Accepts a DIV/DIVU request, runs a radix-2 restoring divide, then presents
//   quotient (LO) and remainder (HI) with a one-cycle HasDiv strobe.
// - Raises busy so the hazard unit can stall dependent MFHI/MFLO instructions.
// PARAMETERS
// WIDTH   32   operand / result width in bits (iteration count = WIDTH)
// PORTS
// clock         in   1      system clock, rising edge
// reset         in   1      asynchronous, active-high; clears all state
// start         in   1      request; sampled only in IDLE
// is_signed     in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
// dividend      in   WIDTH  rs operand; sampled with start
// divisor       in   WIDTH  rt operand; sampled with start
// cancel        in   1      pipeline flush; aborts an in-flight divide
// busy          out  1      high while a divide is in progress
// HasDiv        out  1      one-cycle strobe: DivHi/DivLo are new and valid
// DivHi         out  WIDTH  remainder (HI)
// DivLo         out  WIDTH  quotient (LO)
// div_by_zero   out  1      valid with HasDiv; divisor was 0
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, HasDiv=0, DivHi=0, DivLo=0, div_by_zero=0.
// - States: IDLE -> RUN (start=1 at edge T0) -> FIX (after WIDTH RUN edges) -> IDLE.
// - Operand capture at T0:
//   - Latches |dividend|, |divisor| (magnitudes only when is_signed).
//   - Latches the quotient sign (sign(a)^sign(b)) and the remainder sign
//     (sign(a)).
//   - Clears the partial remainder and the iteration counter; busy=1 from T0.
// - RUN, edges T1..TWIDTH: one restoring step per edge.
//   - Shift {rem,quo} left 1.
//   - trial = rem - divisor.
//   - If trial >= 0: rem = trial and quo[0] = 1.
// - FIX, edge TWIDTH+1:
//   - Negate the quotient if the quotient sign is set; negate the remainder if
//     the remainder sign is set.
//   - Register DivLo/DivHi and set HasDiv=1 for exactly one cycle.
//   - busy=0, return to IDLE.
// - Latency: start at T0 -> HasDiv high in the cycle after T33 (WIDTH=32).
// - DivHi/DivLo hold their value until the next completion or reset.
// - Divisor 0, either mode: DivLo = all-ones, DivHi = dividend (unaltered),
//   div_by_zero=1, same latency.
// - Signed overflow 0x80000000 / 0xFFFFFFFF: DivLo = 0x80000000, DivHi = 0,
//   no flag.
// - start while busy: ignored, operands not re-sampled.
// - start in the same cycle HasDiv is high: state is IDLE, so it is accepted.
// - cancel in RUN/FIX: return to IDLE next edge.
//   - busy=0, no HasDiv.
//   - DivHi/DivLo keep their previous values.
// - cancel with start in IDLE: cancel wins; request dropped.
// - Asynchronous reset mid-divide: immediate IDLE, all outputs 0, no strobe.
// TESTING
// - DIVU 100/7: start at T0 -> HasDiv at T33 only; DivLo=14, DivHi=2; busy high
//   T0..T33.
// - DIV -7/2: DivLo=0xFFFFFFFD (-3), DivHi=0xFFFFFFFF (-1); DIV 7/-2 gives
//   DivLo=-3, DivHi=1.
// - DIV 0x80000000/0xFFFFFFFF: DivLo=0x80000000, DivHi=0, div_by_zero=0.
// - DIVU 5/0 and DIV -5/0: DivLo=0xFFFFFFFF, DivHi=dividend, div_by_zero=1.
// - Second start at T5 with different operands: ignored; first result appears
//   unchanged at T33.
// - reset asserted at cycle 10, or cancel at cycle 10:
//   - busy drops and no HasDiv follows.
//   - After reset, DivHi/DivLo=0; after cancel, DivHi/DivLo keep their old values.

Source files
------------

// File: rtl/hilo_div_unit.sv
// Radix-2 restoring divider producing HI (remainder) and LO (quotient)
// for the decode-stage hi/lo registers; busy stalls MFHI/MFLO consumers.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             HasDiv,
  output logic [WIDTH-1:0] DivHi,
  output logic [WIDTH-1:0] DivLo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic             r_has;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz_o;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic             w_accept;
  logic             w_last;

  assign w_a_neg  = is_signed & dividend[WIDTH-1];
  assign w_b_neg  = is_signed & divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag  = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = w_shift >= {1'b0, r_dvs};
  // Difference fits in WIDTH bits whenever w_ge holds.
  assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;
  assign w_accept = (r_state == S_IDLE) & start & ~cancel;
  assign w_last   = r_cnt == CW'(WIDTH - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_rem  <= '0;
      r_quo  <= w_a_mag;
      r_dvs  <= w_b_mag;
      r_cnt  <= '0;
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_dz   <= divisor == '0;
    end else if (r_state == S_RUN) begin
      r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quo  <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Zero divisor: the remainder ends up as |dividend|, so re-signing it
  // restores the original dividend; the quotient is forced to all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_has  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dz_o <= 1'b0;
    end else if (r_state == S_FIX && !cancel) begin
      r_has  <= 1'b1;
      r_hi   <= r_rneg ? (~r_rem + 1'b1) : r_rem;
      r_lo   <= r_dz ? '1 : (r_qneg ? (~r_quo + 1'b1) : r_quo);
      r_dz_o <= r_dz;
    end else begin
      r_has  <= 1'b0;
    end
  end

  assign busy        = r_state != S_IDLE;
  assign HasDiv      = r_has;
  assign DivHi       = r_hi;
  assign DivLo       = r_lo;
  assign div_by_zero = r_dz_o;

endmodule
